// File: rtl/fetch_line_ctrl.sv
// Instruction fetch line controller: requests icache lines, buffers current + prefetched line, feeds decode one word at a time.
// Latency: a response reaches instr_valid_o one cycle after it lands; one request outstanding at a time.
// Backpressure: request held stable until req_ready_i; instruction held while instr_ready_i=0; flush overrides everything.
module fetch_line_ctrl #(
   parameter int              XLEN       = 64,
   parameter int              ILEN       = 32,
   parameter int              LINE_WORDS = 4,
   parameter int              OFFSET     = 2,
   parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic                       req_valid_o,
   input  logic                       req_ready_i,
   output logic [XLEN-1:0]            req_addr_o,
   input  logic                       resp_valid_i,
   input  logic [LINE_WORDS*ILEN-1:0] resp_line_i,
   output logic                       instr_valid_o,
   input  logic                       instr_ready_i,
   output logic [ILEN-1:0]            instr_o,
   output logic [XLEN-1:0]            instr_pc_o
);

   localparam int              W           = $clog2(LINE_WORDS);
   localparam int              LW          = LINE_WORDS * ILEN;
   localparam logic [XLEN-1:0] LINE_BYTES  = XLEN'(LINE_WORDS * ILEN / 8);
   localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(ILEN / 8);
   localparam logic [XLEN-1:0] LINE_MASK   = ~((XLEN'(1) << (W + OFFSET)) - XLEN'(1));
   localparam logic [XLEN-1:0] INSTR_MASK  = ~((XLEN'(1) << OFFSET) - XLEN'(1));

   // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be thrown away
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t            state_q, state_d;
   logic [LW-1:0]     line_reg_q, line_reg_d;
   logic              line_reg_valid_q, line_reg_valid_d;
   logic [LW-1:0]     line_bak_q, line_bak_d;
   logic              bak_valid_q, bak_valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   nxt_line_addr_q, nxt_line_addr_d;

   logic              req_hs;
   logic              resp_take;
   logic              instr_hs;
   logic              last_word;
   logic              vacate;
   logic [W-1:0]      word_idx;

   assign word_idx      = pc_q[W+OFFSET-1:OFFSET];
   assign last_word     = (word_idx == W'(LINE_WORDS - 1));
   assign instr_hs      = line_reg_valid_q && instr_ready_i;
   assign vacate        = instr_hs && last_word;
   assign req_hs        = req_valid_o && req_ready_i;

   assign req_addr_o    = nxt_line_addr_q;
   assign instr_valid_o = line_reg_valid_q;
   assign instr_o       = line_reg_q[word_idx*ILEN +: ILEN];
   assign instr_pc_o    = pc_q;

   // Port FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Port FSM next state; a flush turns an outstanding kept response into a dropped one
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_hs) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush_i)           state_d = resp_valid_i ? S_IDLE : S_DROP;
            else if (resp_valid_i) state_d = S_IDLE;
         end
         S_DROP: begin
            if (resp_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Port FSM outputs: request only when a line slot is free and nothing is in flight
   always_comb begin
      req_valid_o = (state_q == S_IDLE) && !flush_i && !rst_i &&
                    (!line_reg_valid_q || !bak_valid_q);
      resp_take   = (state_q == S_WAIT) && resp_valid_i && !flush_i;
   end

   // Datapath next state: flush wins, otherwise consume word, shift lines, land response
   always_comb begin
      line_reg_d       = line_reg_q;
      line_reg_valid_d = line_reg_valid_q;
      line_bak_d       = line_bak_q;
      bak_valid_d      = bak_valid_q;
      pc_d             = pc_q;
      nxt_line_addr_d  = nxt_line_addr_q;
      if (flush_i) begin
         line_reg_valid_d = 1'b0;
         bak_valid_d      = 1'b0;
         pc_d             = redirect_pc_i & INSTR_MASK;
         nxt_line_addr_d  = redirect_pc_i & LINE_MASK;
      end else begin
         if (instr_hs) begin
            pc_d = pc_q + INSTR_BYTES;
            if (last_word) begin
               line_reg_d       = line_bak_q;
               line_reg_valid_d = bak_valid_q;
               bak_valid_d      = 1'b0;
            end
         end
         // A response goes straight to line_reg if it is empty, or emptying with nothing in bak
         if (resp_take) begin
            if (!line_reg_valid_q || (vacate && !bak_valid_q)) begin
               line_reg_d       = resp_line_i;
               line_reg_valid_d = 1'b1;
            end else begin
               line_bak_d  = resp_line_i;
               bak_valid_d = 1'b1;
            end
         end
         if (req_hs) begin
            nxt_line_addr_d = nxt_line_addr_q + LINE_BYTES;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         line_reg_q       <= '0;
         line_reg_valid_q <= 1'b0;
         line_bak_q       <= '0;
         bak_valid_q      <= 1'b0;
         pc_q             <= BOOT_PC;
         nxt_line_addr_q  <= BOOT_PC & LINE_MASK;
      end else begin
         line_reg_q       <= line_reg_d;
         line_reg_valid_q <= line_reg_valid_d;
         line_bak_q       <= line_bak_d;
         bak_valid_q      <= bak_valid_d;
         pc_q             <= pc_d;
         nxt_line_addr_q  <= nxt_line_addr_d;
      end
   end

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Bench for fetch_line_ctrl: icache responder plus scoreboards of expected request addresses and instruction PCs.
// Latency: responder answers a configurable number of cycles after each request handshake.
// Backpressure: ready inputs follow scoreboard occupancy unless a step drives them directly.
module tb_fetch_line_ctrl;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic [63:0]  redirect_pc_i;
   logic         req_valid_o;
   logic         req_ready_i;
   logic [63:0]  req_addr_o;
   logic         resp_valid_i;
   logic [127:0] resp_line_i;
   logic         instr_valid_o;
   logic         instr_ready_i;
   logic [31:0]  instr_o;
   logic [63:0]  instr_pc_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_req[$];
   logic [63:0] exp_pc[$];

   bit          auto_irdy = 1'b1;
   bit          auto_qrdy = 1'b1;
   bit          pend      = 1'b0;
   logic [63:0] pend_addr = '0;
   int          pend_wait = 0;
   int          resp_lat  = 1;

   fetch_line_ctrl #(
      .XLEN(64), .ILEN(32), .LINE_WORDS(4), .OFFSET(2), .BOOT_PC(64'h80)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
      .resp_valid_i(resp_valid_i), .resp_line_i(resp_line_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o)
   );

   always #5 clk_i = ~clk_i;

   // Each instruction word holds the low 32 bits of its own address
   function automatic logic [127:0] mk_line(input logic [63:0] addr);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'(addr + 64'(4*k));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at the negative edge: score handshakes, step to just after the rising edge, run the responder
   task automatic finish_cyc();
      logic [63:0] e;
      if (auto_irdy) instr_ready_i = (exp_pc.size() != 0);
      if (auto_qrdy) req_ready_i   = (exp_req.size() != 0);
      if (req_valid_o === 1'b1 && req_ready_i) begin
         if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            chk("req_addr", req_addr_o, e);
         end else begin
            chk("req_extra_qlen", 64'(exp_req.size()), 64'd1);
         end
         chk("req_align", 64'(req_addr_o[3:0]), 64'd0);
         pend      = 1'b1;
         pend_addr = req_addr_o;
         pend_wait = resp_lat - 1;
      end else if (pend && !resp_valid_i) begin
         if (pend_wait > 0) pend_wait--;
      end
      if (instr_valid_o === 1'b1 && instr_ready_i && !flush_i && !rst_i) begin
         if (exp_pc.size() != 0) begin
            e = exp_pc.pop_front();
            chk("instr_pc", instr_pc_o, e);
            chk("instr_dat", 64'(instr_o), e & 64'hFFFF_FFFF);
         end else begin
            chk("instr_extra_qlen", 64'(exp_pc.size()), 64'd1);
         end
      end
      @(posedge clk_i);
      #1;
      if (resp_valid_i) resp_valid_i = 1'b0;
      if (pend && pend_wait == 0 && !resp_valid_i) begin
         resp_valid_i = 1'b1;
         resp_line_i  = mk_line(pend_addr);
         pend         = 1'b0;
      end
   endtask

   task automatic cyc();
      @(negedge clk_i);
      finish_cyc();
   endtask

   task automatic run_until(input int maxc);
      int n = 0;
      while ((exp_pc.size() != 0 || exp_req.size() != 0) && n < maxc) begin
         cyc();
         n++;
      end
      chk("drain_timeout", 64'(exp_pc.size() + exp_req.size()), 64'd0);
   endtask

   initial begin
      int n;
      rst_i = 1'b1; flush_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
      resp_valid_i = 1'b0; resp_line_i = '0; instr_ready_i = 1'b0;

      // Reset state
      cyc(); cyc();
      @(negedge clk_i);
      chk("rst_req_valid", 64'(req_valid_o), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid_o), 64'd0);
      chk("rst_instr", 64'(instr_o), 64'd0);
      chk("rst_pc", instr_pc_o, 64'h80);
      finish_cyc();

      // Boot: two lines, streaming with no bubble across the line boundary
      rst_i = 1'b0;
      exp_req.push_back(64'h80); exp_req.push_back(64'h90); exp_req.push_back(64'hA0);
      for (int i = 0; i < 5; i++) exp_pc.push_back(64'h80 + 64'(4*i));
      @(negedge clk_i);
      chk("boot_req_valid", 64'(req_valid_o), 64'd1);
      chk("boot_req_addr", req_addr_o, 64'h80);
      finish_cyc();
      n = 0;
      @(negedge clk_i);
      while (instr_valid_o !== 1'b1 && n < 20) begin
         finish_cyc();
         @(negedge clk_i);
         n++;
      end
      chk("first_line_timeout", 64'(instr_valid_o), 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk_i);
         chk("no_bubble", 64'(instr_valid_o), 64'd1);
         finish_cyc();
      end

      // Decode stall: output held, both line slots fill, then no more requests
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         chk("stall_pc", instr_pc_o, 64'h94);
         chk("stall_instr", 64'(instr_o), 64'h94);
         finish_cyc();
      end
      @(negedge clk_i);
      chk("stall_no_req", 64'(req_valid_o), 64'd0);
      chk("stall_valid", 64'(instr_valid_o), 64'd1);
      finish_cyc();

      // Redirect into the middle of a line; last word of 0x1C0 meets the 0x1D0 response
      exp_req.push_back(64'h1C0); exp_req.push_back(64'h1D0);
      exp_pc.push_back(64'h1C8); exp_pc.push_back(64'h1CC); exp_pc.push_back(64'h1D0);
      flush_i = 1'b1; redirect_pc_i = 64'h1CA;
      @(negedge clk_i);
      chk("flush_no_req", 64'(req_valid_o), 64'd0);
      finish_cyc();
      flush_i = 1'b0;
      run_until(40);

      // Request held while the icache is not ready
      auto_qrdy = 1'b0; req_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("hold_req_valid", 64'(req_valid_o), 64'd1);
         chk("hold_req_addr", req_addr_o, 64'h1E0);
         finish_cyc();
      end
      exp_req.push_back(64'h1E0);
      auto_qrdy = 1'b1;
      run_until(10);

      // Flush while waiting; the stale response arrives two cycles later and is dropped
      resp_lat = 3;
      exp_req.push_back(64'h300);
      flush_i = 1'b1; redirect_pc_i = 64'h300;
      cyc();
      flush_i = 1'b0;
      cyc();
      exp_req.push_back(64'h400);
      exp_pc.push_back(64'h400); exp_pc.push_back(64'h404);
      flush_i = 1'b1; redirect_pc_i = 64'h400;
      cyc();
      flush_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("drop_instr_valid", 64'(instr_valid_o), 64'd0);
         if (i < 2) chk("drop_no_req", 64'(req_valid_o), 64'd0);
         finish_cyc();
      end
      run_until(40);

      // Flush in the same cycle the response arrives: discarded, next request immediate
      resp_lat = 1;
      exp_req.push_back(64'h500);
      flush_i = 1'b1; redirect_pc_i = 64'h500;
      cyc();
      flush_i = 1'b0;
      cyc();
      exp_req.push_back(64'h600);
      exp_pc.push_back(64'h600); exp_pc.push_back(64'h604);
      flush_i = 1'b1; redirect_pc_i = 64'h600;
      cyc();
      flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_resp_req_valid", 64'(req_valid_o), 64'd1);
      chk("flush_resp_req_addr", req_addr_o, 64'h600);
      finish_cyc();
      run_until(40);

      // Reset mid-transaction: late response arrives in IDLE and is ignored
      resp_lat = 3;
      exp_req.push_back(64'h700);
      flush_i = 1'b1; redirect_pc_i = 64'h700;
      cyc();
      flush_i = 1'b0;
      cyc();
      auto_qrdy = 1'b0; req_ready_i = 1'b0;
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("post_rst_req_valid", 64'(req_valid_o), 64'd1);
         chk("post_rst_req_addr", req_addr_o, 64'h80);
         chk("post_rst_instr_valid", 64'(instr_valid_o), 64'd0);
         finish_cyc();
      end
      resp_lat = 1;
      exp_req.push_back(64'h80);
      exp_pc.push_back(64'h80); exp_pc.push_back(64'h84);
      auto_qrdy = 1'b1;
      run_until(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_line_ctrl.md
FETCH_LINE_CTRL -- requirements
Module: fetch_line_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 4, sets the number of ILEN instructions per cache line; it SHALL be a power of two ≥2, and W = log2(LINE_WORDS).
REQ-002 Parameter OFFSET, default 2, sets the byte-offset bits per instruction and SHALL equal log2(ILEN/8).
REQ-003 Parameter BOOT_PC, default 0, sets the fetch address after reset.
REQ-004 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 flush_i  in  1  redirect request.
REQ-007 redirect_pc_i  in  XLEN  new fetch address.
REQ-008 req_valid_o  out  1  line request valid to the icache.
REQ-009 req_ready_i  in  1  icache accepts the request.
REQ-010 req_addr_o  out  XLEN  line-aligned request address, with the low W+OFFSET bits zero.
REQ-011 resp_valid_i  in  1  line response valid.
REQ-012 resp_line_i  in  LINE_WORDS*ILEN  line data; word k is at bits [k*ILEN +: ILEN].
REQ-013 instr_valid_o  out  1  instruction valid to decode.
REQ-014 instr_ready_i  in  1  decode accepts the instruction.
REQ-015 instr_o  out  ILEN  current instruction.
REQ-016 instr_pc_o  out  XLEN  address of instr_o.

Function
REQ-017 State SHALL be held in these registers: line_reg/line_reg_valid (current line), line_bak/bak_valid (prefetched line), pc, nxt_line_addr, and a port FSM.
REQ-018 The port FSM SHALL have three states: IDLE = no request outstanding; WAIT = one request outstanding, response to be kept; DROP = one request outstanding, response to be discarded.
REQ-019 req_valid_o SHALL be 1 only when all of the following hold: FSM is IDLE, flush_i=0, and (line_reg_valid=0 or bak_valid=0).
REQ-020 req_addr_o SHALL equal nxt_line_addr.
REQ-021 Once req_valid_o is asserted, req_valid_o and req_addr_o SHALL stay stable until req_ready_i=1, except when a flush occurs.
REQ-022 On a request handshake: IDLE→WAIT, and nxt_line_addr += LINE_WORDS*ILEN/8, wrapping modulo 2^XLEN.
REQ-023 At most one request SHALL be outstanding; responses are in order and arrive at least 1 cycle after the handshake.
REQ-024 A response in WAIT SHALL load line_reg if line_reg_valid=0 (or if line_reg is being vacated that cycle and bak_valid=0), otherwise line_bak; the FSM then returns to IDLE.
REQ-025 A response in DROP SHALL be discarded, with DROP→IDLE.
REQ-026 resp_valid_i in IDLE SHALL be ignored.
REQ-027 instr_valid_o SHALL equal line_reg_valid.
REQ-028 instr_o SHALL be word pc[W+OFFSET-1:OFFSET] of line_reg, and instr_pc_o SHALL equal pc.
REQ-029 On an instruction handshake, pc SHALL advance by ILEN/8.
REQ-030 If the consumed word is word LINE_WORDS-1: line_reg←line_bak, line_reg_valid←bak_valid, bak_valid←0.
REQ-031 Latency from a response landing in line_reg to instr_valid_o=1 SHALL be 1 cycle.
REQ-032 With instr_ready_i=1 continuously and a response latency of 1 cycle, prefetch SHALL sustain at least one instruction per cycle after the first line.
REQ-033 flush_i SHALL take priority over every same-cycle event.
REQ-034 On flush: line_reg_valid←0; bak_valid←0.
REQ-035 On flush: pc←redirect_pc_i with the low OFFSET bits cleared.
REQ-036 On flush: nxt_line_addr←redirect_pc_i with the low W+OFFSET bits cleared.
REQ-037 On flush: the FSM goes WAIT→DROP, or WAIT→IDLE if resp_valid_i=1 in the same cycle, in which case that response is discarded.
REQ-038 A flush in DROP SHALL stay in DROP; a flush in IDLE SHALL stay in IDLE.
REQ-039 Redirect into mid-line: output SHALL start at word redirect_pc_i[W+OFFSET-1:OFFSET], and earlier words of that line SHALL never be presented.
REQ-040 A flush in the same cycle as an instruction handshake SHALL discard the advance; pc takes the redirect value.

Reset
REQ-041 While rst_i=1 at a clock edge, the block SHALL set: FSM=IDLE, line_reg_valid=0, bak_valid=0, line_reg=0, line_bak=0, pc=BOOT_PC, nxt_line_addr=BOOT_PC with the low W+OFFSET bits cleared.
REQ-042 Consequently, after reset: req_valid_o=0 during the reset cycle, instr_valid_o=0, instr_o=0, instr_pc_o=BOOT_PC.
REQ-043 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response then arrives in IDLE and SHALL be ignored.
REQ-044 The first cycle after reset release SHALL assert req_valid_o with the aligned BOOT_PC.

Verification (XLEN=64, ILEN=32, LINE_WORDS=4, BOOT_PC=0x80)
REQ-045 Reset release, req_ready_i=1, and a 1-cycle response → requests go to 0x80 then 0x90; instr_pc_o sequence is 0x80, 0x84, 0x88, 0x8C, 0x90 with no bubble after the first line.
REQ-046 flush_i with redirect_pc_i=0x1CA → req_addr_o=0x1C0; first instr_pc_o=0x1C8 (word 2), then 0x1CC, then 0x1D0.
REQ-047 Flush in WAIT, then the response arrives 2 cycles later → the response is dropped and instr_valid_o stays 0 until the redirect line returns; the next req_addr_o is the redirect line.
REQ-048 instr_ready_i=0 for 6 cycles → instr_o/instr_pc_o are stable; exactly two lines are requested (line_reg + line_bak), then req_valid_o=0.
REQ-049 req_ready_i=0 for 3 cycles → req_valid_o=1 and req_addr_o are held constant until the handshake.
REQ-050 Last word 0x8C consumed in the same cycle as a response for 0x90 with bak empty → the response lands in line_reg; the next cycle has instr_valid_o=1 and instr_pc_o=0x90.
